ps2_kbd_rx: RTL

PS/2 keyboard receiver on the CPU I/O side. Drives the board's PS2_CLK/PS2_DAT lines as inputs only, deframes 11-bit device-to-host frames and buffers scan codes in a FIFO. The CPU's memory-mapped I/O decode pops the FIFO, making this the input-side counterpart to the VRAM/VGA output path. Runs entirely in the 50 MHz CLK domain.

---
 rtl/ps2_kbd_rx.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: conditions the raw PS/2 pins, deframes 11-bit
// device-to-host frames and buffers scan codes in a show-ahead FIFO popped by
// the CPU I/O decode. Single CLK domain.
//
// Optional feature: define PS2_BREAK_DECODE_EN to fold the 0xF0 break prefix
// into bit 8 of the following byte instead of pushing it.
//
// Ports:
//   CLK, RST        50 MHz clock, synchronous active-high reset
//   ps2_clk/ps2_dat raw asynchronous PS/2 pins
//   rd_en           pop the head entry (ignored when empty)
//   rd_data         head entry {break, scan[7:0]}, valid while empty=0
//   empty, count    FIFO status
//   overflow        sticky: byte dropped on full FIFO
//   parity_err      sticky: frame rejected on parity failure
//   frame_err       sticky: bad start/stop bit or inter-edge timeout
//   clr_err         clears the three sticky flags (a new event wins)
module ps2_kbd_rx #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned FILT    = 8,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ps2_clk,
    input  logic                     ps2_dat,
    input  logic                     rd_en,
    output logic [8:0]               rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     parity_err,
    output logic                     frame_err,
    input  logic                     clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FILT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          strobe;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
`ifdef PS2_BREAK_DECODE_EN
    logic          brk_armed;
`endif

    logic          frame_bad_c, par_bad_c, byte_ok_c, timeout_c, push_c;
    logic [8:0]    push_word_c;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_n;
    logic [CW-1:0] count_n;
    logic [8:0]    head_n;
    logic          full, do_pop, do_push;

    // Synchronizers and PS/2 clock glitch filter; strobe marks a filtered falling edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
            strobe <= 1'b0;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT - 1)) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
                strobe   <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Frame verdict at the stop-bit strobe, and inter-edge timeout.
    always_comb begin
        frame_bad_c = strobe && (state == STOP) && !dat_s2;
        par_bad_c   = strobe && (state == STOP) && dat_s2 && !(^{shreg, par_bit});
        byte_ok_c   = strobe && (state == STOP) && dat_s2 && (^{shreg, par_bit});
        timeout_c   = (state != IDLE) && !strobe && (to_cnt == TW'(TIMEOUT - 1));
`ifdef PS2_BREAK_DECODE_EN
        push_c      = byte_ok_c && (shreg != 8'hF0);
        push_word_c = {brk_armed, shreg};
`else
        push_c      = byte_ok_c;
        push_word_c = {1'b0, shreg};
`endif
    end

    // Deframer FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
`ifdef PS2_BREAK_DECODE_EN
            brk_armed <= 1'b0;
`endif
        end else begin
            if (state == IDLE || strobe) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end

            if (timeout_c) begin
                state <= IDLE;
`ifdef PS2_BREAK_DECODE_EN
                brk_armed <= 1'b0;
`endif
            end else if (strobe) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
`ifdef PS2_BREAK_DECODE_EN
                        // Errors and any pushed (or dropped) byte disarm; 0xF0 arms.
                        brk_armed <= byte_ok_c && (shreg == 8'hF0);
`endif
                    end
                endcase
            end
        end
    end

    // FIFO control: next pointers, count and show-ahead head (bypass when writing the new head).
    always_comb begin
        full    = (count == CW'(DEPTH));
        do_pop  = rd_en && !empty;
        do_push = push_c && (!full || do_pop);
        rptr_n  = do_pop ? rptr + AW'(1) : rptr;
        count_n = count;
        if (do_push && !do_pop) count_n = count + CW'(1);
        if (!do_push && do_pop) count_n = count - CW'(1);
        head_n  = (do_push && (wptr == rptr_n)) ? push_word_c : mem[rptr_n];
    end

    // FIFO storage.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr] <= push_word_c;
    end

    // FIFO pointers, status outputs and sticky error flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            empty      <= 1'b1;
            rd_data    <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            rptr    <= rptr_n;
            count   <= count_n;
            empty   <= (count_n == '0);
            rd_data <= head_n;

            if (push_c && full && !do_pop) overflow <= 1'b1;
            else if (clr_err)              overflow <= 1'b0;

            if (par_bad_c)    parity_err <= 1'b1;
            else if (clr_err) parity_err <= 1'b0;

            if (frame_bad_c || timeout_c) frame_err <= 1'b1;
            else if (clr_err)             frame_err <= 1'b0;
        end
    end

endmodule
